player_action_ctrl: RTL and testbench
=====================================

PLAYER_ACTION_CTRL -- requirements
Module: player_action_ctrl

Interface
REQ-001 Parameters SHALL be: PUNCH_FRAMES, default 8, punch duration in frames; PUNCH_COOLDOWN, default 4, frames before the next punch is accepted; JUMP_FRAMES, default 16, jump duration in frames; INVULN_FRAMES, default 16, post-hit immunity in frames; MAX_HEALTH, default 7, health after reset or restart (range 1..7).
REQ-002 Clk  in  1  single clock for all logic.
REQ-003 Reset_n  in  1  asynchronous, active-low reset.
REQ-004 frame_clk  in  1  vertical-sync level, synchronous to Clk; each rising edge is one frame tick.
REQ-005 key_punch, key_jump, key_crouch, key_left, key_right  in  1 each  level key states.
REQ-006 hit  in  1  one-cycle damage pulse, accepted on any cycle.
REQ-007 restart  in  1  level; leaves DEAD at the next frame tick.
REQ-008 punch, jump, crouch, left, right, death  out  1 each  registered action bits that drive the sprite selector.
REQ-009 health  out  3  current health.
REQ-010 invuln  out  1  high while hits are ignored.

Function
REQ-011 frame_tick SHALL equal frame_clk & ~frame_clk_q (registered previous value). All state, counter and output updates except hit capture SHALL occur on the Clk edge that ends a frame_tick cycle (latency 1 Clk).
REQ-012 Main FSM states SHALL be IDLE, JUMP, CROUCH and DEAD.
REQ-013 Priority at a tick SHALL be: pending hit, then death, then crouch, then jump and punch, then movement.
REQ-014 IDLE -> CROUCH when key_crouch=1; CROUCH -> IDLE at the first tick with key_crouch=0; crouch=1 exactly in CROUCH.
REQ-015 IDLE -> JUMP when key_jump=1 and key_crouch=0; jump=1 for exactly JUMP_FRAMES ticks, then -> IDLE; key_crouch SHALL be ignored during JUMP.
REQ-016 A punch SHALL start at a tick when key_punch=1, the state is IDLE or JUMP, and both punch counters are 0.
REQ-017 Once started, punch=1 for PUNCH_FRAMES ticks, followed by PUNCH_COOLDOWN ticks with punch=0 during which key_punch is ignored.
REQ-018 A punch that is active when JUMP ends SHALL continue.
REQ-019 Entering CROUCH or DEAD SHALL clear the punch and cooldown counters.
REQ-020 left and right SHALL follow key_left and key_right in IDLE and JUMP, SHALL be 0 in CROUCH and DEAD, and both may be 1.
REQ-021 hit SHALL set a pending flag, which is consumed at the next tick; several hits within one frame SHALL count as one.
REQ-022 If pending and invuln=0, health SHALL decrement by 1 and invuln=1 for INVULN_FRAMES ticks.
REQ-023 If pending and invuln=1, the hit SHALL be discarded.
REQ-024 health SHALL saturate at 0; a decrement to 0 SHALL enter DEAD at the same tick.
REQ-025 In DEAD, death=1 and all other action bits SHALL be 0.
REQ-026 DEAD SHALL be left only at a tick with restart=1, which goes to IDLE, sets health=MAX_HEALTH and clears all counters and the pending flag.
REQ-027 A hit and a punch start in the same tick SHALL apply the hit first; if that hit kills, the punch SHALL NOT start.

Reset
REQ-028 Reset_n=0 SHALL immediately set: state IDLE; all action bits 0; health=MAX_HEALTH; invuln=0; all counters, the pending flag and frame_clk_q = 0.
REQ-029 Reset asserted mid-jump, mid-punch or in DEAD SHALL abort the operation with no residual count.
REQ-030 The first tick after release SHALL require a new 0->1 edge on frame_clk.

Structure
REQ-031 Package player_pkg SHALL hold the state enum and the default frame and health constants.
REQ-032 The frame-edge detector SHALL be sub-module frame_tick_gen (Clk, Reset_n, frame_clk -> frame_tick).
REQ-033 The remainder SHALL be a single module: one FSM plus counters of at most 5 bits.

Verification
REQ-034 Jump: key_jump=1 for 1 tick from IDLE -> jump=1 for exactly 16 ticks, then 0 and state IDLE.
REQ-035 Punch: key_punch held -> punch high 8 ticks, low 4, high again at tick 13.
REQ-036 Punch in jump: key_punch at jump tick 12 -> punch=1 ticks 12-19 with jump=0 from tick 16.
REQ-037 Hits: hit pulses at frames 0, 5 and 20 -> health 7->6 at frame 0, 5 ignored (invuln), 6->5 at frame 20.
REQ-038 Death and restart: health 1, hit plus key_punch in the same frame -> death=1, punch=0, health=0; restart=1 -> IDLE, health=7.
REQ-039 Reset: Reset_n=0 asserted at jump tick 7 -> outputs 0 with no clock edge; after release, no tick without a new frame_clk edge.

Source files
------------

// File: rtl/player_pkg.sv
// player_pkg: player FSM state encoding plus default frame timings and health
package player_pkg;
  typedef enum logic [1:0] {IDLE, JUMP, CROUCH, DEAD} state_t;
  localparam int CNT_W = 5;
  localparam int DEF_PUNCH_FRAMES = 8;
  localparam int DEF_PUNCH_COOLDOWN = 4;
  localparam int DEF_JUMP_FRAMES = 16;
  localparam int DEF_INVULN_FRAMES = 16;
  localparam int DEF_MAX_HEALTH = 7;
endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: one-cycle tick on each rising edge of the frame_clk level.
// Ticks are suppressed until frame_clk has been seen low, so a level held high across reset never ticks.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic frame_tick
);
  logic r_frame_q, r_armed;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      r_frame_q <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_frame_q <= frame_clk;
      r_armed <= r_armed | ~frame_clk;
    end
  assign frame_tick = frame_clk & ~r_frame_q & r_armed;
endmodule

// File: rtl/player_action_ctrl.sv
// player_action_ctrl: frame-stepped player FSM producing sprite action bits, health and hit immunity
module player_action_ctrl
  import player_pkg::*;
#(
  parameter int PUNCH_FRAMES = DEF_PUNCH_FRAMES,
  parameter int PUNCH_COOLDOWN = DEF_PUNCH_COOLDOWN,
  parameter int JUMP_FRAMES = DEF_JUMP_FRAMES,
  parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
  parameter int MAX_HEALTH = DEF_MAX_HEALTH
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       key_punch,
  input  logic       key_jump,
  input  logic       key_crouch,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       hit,
  input  logic       restart,
  output logic       punch,
  output logic       jump,
  output logic       crouch,
  output logic       left,
  output logic       right,
  output logic       death,
  output logic [2:0] health,
  output logic       invuln
);
  typedef logic [CNT_W-1:0] cnt_t;
  state_t r_state, w_state_n;
  cnt_t r_jcnt, r_pcnt, r_ccnt, r_inv, w_jcnt_n, w_pcnt_n, w_ccnt_n, w_inv_n;
  logic [2:0] r_health, w_health_n;
  logic r_pend, w_tick, w_pend, w_take, w_move;
  logic r_punch, r_jump, r_crouch, r_left, r_right, r_death;
  frame_tick_gen u_tick (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .frame_clk(frame_clk),
    .frame_tick(w_tick)
  );
  // a hit arriving in the tick cycle itself still lands on this tick
  assign w_pend = r_pend | hit;
  assign w_take = w_pend && r_inv == '0 && r_state != DEAD;
  assign w_move = w_state_n == IDLE || w_state_n == JUMP;
  always_comb begin
    w_state_n = r_state;
    w_health_n = w_take ? r_health - 3'd1 : r_health;
    w_inv_n = w_take ? cnt_t'(INVULN_FRAMES) : (r_inv != '0 ? r_inv - cnt_t'(1) : '0);
    w_jcnt_n = r_jcnt;
    w_pcnt_n = r_pcnt != '0 ? r_pcnt - cnt_t'(1) : '0;
    w_ccnt_n = r_pcnt == cnt_t'(1) ? cnt_t'(PUNCH_COOLDOWN) : (r_ccnt != '0 ? r_ccnt - cnt_t'(1) : '0);
    if (r_state == DEAD) begin
      if (restart) begin
        w_state_n = IDLE;
        w_health_n = 3'(MAX_HEALTH);
        w_inv_n = '0;
      end
    end else if (w_take && r_health == 3'd1) w_state_n = DEAD;
    else if (r_state == CROUCH) w_state_n = key_crouch ? CROUCH : IDLE;
    else if (r_state == IDLE && key_crouch) w_state_n = CROUCH;
    else begin
      if (r_state == JUMP) begin
        w_jcnt_n = r_jcnt - cnt_t'(1);
        w_state_n = r_jcnt == cnt_t'(1) ? IDLE : JUMP;
      end else if (key_jump) begin
        w_jcnt_n = cnt_t'(JUMP_FRAMES);
        w_state_n = JUMP;
      end
      if (key_punch && w_pcnt_n == '0 && w_ccnt_n == '0) w_pcnt_n = cnt_t'(PUNCH_FRAMES);
    end
    if (w_state_n == CROUCH || w_state_n == DEAD) begin
      w_jcnt_n = '0;
      w_pcnt_n = '0;
      w_ccnt_n = '0;
    end
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      r_state <= IDLE;
      r_health <= 3'(MAX_HEALTH);
      r_pend <= 1'b0;
      r_jcnt <= '0;
      r_pcnt <= '0;
      r_ccnt <= '0;
      r_inv <= '0;
      r_punch <= 1'b0;
      r_jump <= 1'b0;
      r_crouch <= 1'b0;
      r_left <= 1'b0;
      r_right <= 1'b0;
      r_death <= 1'b0;
    end else begin
      r_pend <= w_tick ? 1'b0 : w_pend;
      if (w_tick) begin
        r_state <= w_state_n;
        r_health <= w_health_n;
        r_jcnt <= w_jcnt_n;
        r_pcnt <= w_pcnt_n;
        r_ccnt <= w_ccnt_n;
        r_inv <= w_inv_n;
        r_punch <= w_pcnt_n != '0;
        r_jump <= w_state_n == JUMP;
        r_crouch <= w_state_n == CROUCH;
        r_death <= w_state_n == DEAD;
        r_left <= key_left & w_move;
        r_right <= key_right & w_move;
      end
    end
  assign punch = r_punch;
  assign jump = r_jump;
  assign crouch = r_crouch;
  assign left = r_left;
  assign right = r_right;
  assign death = r_death;
  assign health = r_health;
  assign invuln = r_inv != '0;
endmodule

// File: tb/tb_player_action_ctrl.sv
// tb_player_action_ctrl: scoreboard bench; a frame-level reference model queues the expected outputs per tick
module tb_player_action_ctrl;
  localparam int PF = 8, PC = 4, JF = 16, IVF = 16, MH = 7;
  localparam int NONE = -1000;
  logic Clk = 1'b0, Reset_n = 1'b0, frame_clk = 1'b0;
  logic key_punch = 1'b0, key_jump = 1'b0, key_crouch = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic hit = 1'b0, restart = 1'b0;
  logic punch, jump, crouch, left, right, death, invuln;
  logic [2:0] health;
  player_action_ctrl #(
    .PUNCH_FRAMES(PF),
    .PUNCH_COOLDOWN(PC),
    .JUMP_FRAMES(JF),
    .INVULN_FRAMES(IVF),
    .MAX_HEALTH(MH)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .frame_clk(frame_clk),
    .key_punch(key_punch),
    .key_jump(key_jump),
    .key_crouch(key_crouch),
    .key_left(key_left),
    .key_right(key_right),
    .hit(hit),
    .restart(restart),
    .punch(punch),
    .jump(jump),
    .crouch(crouch),
    .left(left),
    .right(right),
    .death(death),
    .health(health),
    .invuln(invuln)
  );
  always #5 Clk = ~Clk;
  wire [9:0] act = {punch, jump, crouch, left, right, death, health, invuln};
  localparam logic [9:0] RST_VEC = {6'b0, 3'(MH), 1'b0};
  logic [9:0] exp_q[$];
  int checks = 0, errors = 0;
  bit chk_now = 1'b0, fprev = 1'b1;
  // model: frames are numbered from reset; activities are remembered by the frame they started in
  int f, js, ps, hf, m_health;
  bit hh, m_jump, m_crouch, m_dead, m_inv, m_punch, m_left, m_right;
  task automatic check(input string name, input logic [9:0] a, input logic [9:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b (punch,jump,crouch,left,right,death,health,invuln)", name, a, e);
    end
  endtask
  function automatic void model_reset();
    f = 0; js = NONE; ps = NONE; hf = 0; hh = 0; m_health = MH;
    {m_jump, m_crouch, m_dead, m_inv, m_punch, m_left, m_right} = '0;
  endfunction
  function automatic void model_step(input bit kp, kj, kc, kl, kr, hit_any, rs);
    bit take, nj, nc, nd;
    take = hit_any && !m_inv && !m_dead;
    if (take) begin m_health--; hf = f; hh = 1; end
    nj = 0; nc = 0; nd = 0;
    if (m_dead) begin
      nd = !rs;
      if (rs) begin m_health = MH; hh = 0; js = NONE; ps = NONE; end
    end else if (take && m_health == 0) begin
      nd = 1; js = NONE; ps = NONE;
    end else if (m_crouch) nc = kc;
    else if (!m_jump && kc) begin nc = 1; ps = NONE; js = NONE; end
    else begin
      if (!m_jump && kj) js = f;
      nj = f - js < JF;
      if (kp && f - ps >= PF + PC) ps = f;
    end
    m_jump = nj; m_crouch = nc; m_dead = nd;
    m_inv = hh && f - hf < IVF;
    m_punch = f - ps < PF;
    m_left = kl && !nc && !nd;
    m_right = kr && !nc && !nd;
    f++;
  endfunction
  function automatic logic [9:0] mvec();
    return {m_punch, m_jump, m_crouch, m_left, m_right, m_dead, 3'(m_health), m_inv};
  endfunction
  always @(posedge Clk) begin
    if (!Reset_n) begin chk_now = 0; fprev = 1; end
    else begin chk_now = frame_clk && !fprev; fprev = frame_clk; end
  end
  always @(negedge Clk) if (chk_now) begin
    chk_now = 0;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_tick: got %b expected no tick", act);
    end else check($sformatf("tick_%0d", checks), act, exp_q.pop_front());
  end
  task automatic frame(input bit kp, kj, kc, kl, kr, input int nhit, input bit rs);
    @(negedge Clk);
    frame_clk = 0;
    {key_punch, key_jump, key_crouch, key_left, key_right, restart} = {kp, kj, kc, kl, kr, rs};
    @(negedge Clk);
    repeat (nhit) begin
      hit = 1; @(negedge Clk);
      hit = 0; @(negedge Clk);
    end
    model_step(kp, kj, kc, kl, kr, nhit > 0, rs);
    exp_q.push_back(mvec());
    frame_clk = 1;
  endtask
  task automatic idle(input int n);
    repeat (n) frame(0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    model_reset();
    repeat (3) @(negedge Clk);
    Reset_n = 1;
    check("reset_state", act, RST_VEC);
    idle(2);
    frame(0, 1, 0, 1, 0, 0, 0);
    idle(20);
    repeat (20) frame(1, 0, 0, 0, 1, 0, 0);
    idle(4);
    frame(0, 1, 0, 0, 0, 0, 0);
    idle(11);
    frame(1, 0, 0, 0, 0, 0, 0);
    idle(10);
    frame(0, 0, 1, 1, 1, 0, 0);
    frame(1, 1, 1, 1, 0, 0, 0);
    frame(0, 1, 0, 1, 1, 0, 0);
    frame(0, 0, 1, 0, 0, 0, 0);
    idle(20);
    for (int i = 0; i <= 20; i++) frame(0, 0, 0, 0, 0, (i == 0 || i == 5 || i == 20) ? 1 : 0, 0);
    idle(IVF);
    while (m_health > 1) begin
      frame(0, 0, 0, 0, 0, 2, 0);
      idle(IVF);
    end
    frame(1, 0, 0, 0, 0, 1, 0);
    frame(1, 1, 1, 1, 1, 0, 0);
    frame(0, 0, 0, 0, 0, 1, 0);
    frame(0, 0, 0, 1, 0, 0, 1);
    idle(3);
    frame(1, 1, 0, 0, 0, 0, 0);
    repeat (7) frame(0, 0, 0, 0, 0, 0, 0);
    @(negedge Clk);
    #2 Reset_n = 0;
    #1 check("async_reset", act, RST_VEC);
    key_jump = 1;
    repeat (2) @(negedge Clk);
    Reset_n = 1;
    model_reset();
    repeat (4) @(negedge Clk);
    check("no_tick_after_release", act, RST_VEC);
    key_jump = 0;
    idle(2);
    for (int i = 0; i < 400; i++)
      frame(1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0,
            m_dead ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0));
    repeat (3) @(negedge Clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_ticks: got %0d unchecked expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
